// File: rtl/mem_resp_ctrl_pkg.sv
// Shared widths, state/op encodings and address helper for the memory responder.
package mem_resp_ctrl_pkg;

  localparam int MEM_ADDR_W  = 14;
  localparam int MEM_WDATA_W = 16;
  localparam int MEM_RDATA_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    RD      = 3'd2,
    WR_LO   = 3'd3,
    WR_HI   = 3'd4,
    RESP    = 3'd5,
    RELEASE = 3'd6
  } mem_state_t;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_t;

  // Address plus one with the carry kept, so the top byte of a write can be range-checked.
  function automatic logic [MEM_ADDR_W:0] addr_inc(input logic [MEM_ADDR_W-1:0] a);
    return {1'b0, a} + {{MEM_ADDR_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_resp_ctrl_if.sv
// Requester <-> responder bus. mem_err exists only with MEM_RESP_CTRL_RANGE_CHK_EN.
interface mem_resp_ctrl_if;
  import mem_resp_ctrl_pkg::*;

  logic                   cs;
  logic                   read_req;
  logic                   write_req;
  logic [MEM_ADDR_W-1:0]  addrout;
  logic [MEM_WDATA_W-1:0] datatomem;
  logic [MEM_RDATA_W-1:0] datafrommem;
  logic                   mem_resp;
  logic                   busy;
`ifdef MEM_RESP_CTRL_RANGE_CHK_EN
  logic                   mem_err;
`endif

  modport master (
    output cs, read_req, write_req, addrout, datatomem,
`ifdef MEM_RESP_CTRL_RANGE_CHK_EN
    input  mem_err,
`endif
    input  datafrommem, mem_resp, busy
  );

  modport slave (
    input  cs, read_req, write_req, addrout, datatomem,
`ifdef MEM_RESP_CTRL_RANGE_CHK_EN
    output mem_err,
`endif
    output datafrommem, mem_resp, busy
  );

endinterface

// File: rtl/mem_resp_ctrl_byte_ram.sv
// DEPTH x 8 single-port byte array: synchronous write, combinational read, contents not reset.
module mem_byte_ram #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // Byte write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory responder: latency wait, byte-serialised 16-bit writes, 8-bit reads, one-cycle mem_resp.
// Optional range checking and mem_err output with MEM_RESP_CTRL_RANGE_CHK_EN.
module mem_resp_ctrl
  import mem_resp_ctrl_pkg::*;
#(
  parameter int DEPTH   = 16384,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_resp_ctrl_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]         CNT_LOAD  = CW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [MEM_ADDR_W-1:0] ADDR_MASK = MEM_ADDR_W'(DEPTH - 1);
  localparam logic [MEM_ADDR_W:0]   DEPTH_X   = (MEM_ADDR_W + 1)'(DEPTH);

  mem_state_t             state_q, state_d;
  mem_op_t                op_q, op_d;
  logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
  logic [MEM_WDATA_W-1:0] data_q, data_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MEM_RDATA_W-1:0] rdata_q, rdata_d;
  logic                   resp_q, resp_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic [MEM_ADDR_W-1:0]  addr_in_s;
  logic                   range_err_s;
  logic                   ram_we_s;
  logic [AW-1:0]          ram_addr_s;
  logic [7:0]             ram_wdata_s;
  logic [7:0]             ram_rdata_s;

`ifdef MEM_RESP_CTRL_RANGE_CHK_EN
  assign addr_in_s   = bus.addrout;
  assign range_err_s = (op_q == MEM_WR) ? (addr_inc(addr_q) >= DEPTH_X)
                                        : ({1'b0, addr_q} >= DEPTH_X);
  assign bus.mem_err = err_q;
`else
  assign addr_in_s   = bus.addrout & ADDR_MASK;
  assign range_err_s = 1'b0;
`endif

  // Array port: WR_HI targets addr+1 (wrapping in AW bits); reset blocks any pending write.
  always_comb begin
    ram_we_s = ((state_q == WR_LO) || (state_q == WR_HI)) && !range_err_s && !reset;
    if (state_q == WR_HI) begin
      ram_addr_s  = addr_q[AW-1:0] + AW'(1);
      ram_wdata_s = data_q[15:8];
    end else begin
      ram_addr_s  = addr_q[AW-1:0];
      ram_wdata_s = data_q[7:0];
    end
  end

  mem_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cs && (bus.read_req || bus.write_req)) begin
          op_d   = bus.write_req ? MEM_WR : MEM_RD;
          addr_d = addr_in_s;
          data_d = bus.datatomem;
          cnt_d  = CNT_LOAD;
          if (LATENCY == 0) begin
            state_d = bus.write_req ? WR_LO : RD;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = (op_q == MEM_WR) ? WR_LO : RD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD: begin
        rdata_d = range_err_s ? 8'hFF : ram_rdata_s;
        state_d = RESP;
      end
      WR_LO:   state_d = WR_HI;
      WR_HI:   state_d = RESP;
      RESP:    state_d = RELEASE;
      // Hold here until the requester drops its level so it is not accepted twice.
      RELEASE: begin
        if (!bus.read_req && !bus.write_req) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
    resp_d = (state_q == RESP);
    err_d  = (state_q == RESP) && range_err_s;
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MEM_RD;
      addr_q  <= {MEM_ADDR_W{1'b0}};
      data_q  <= {MEM_WDATA_W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      rdata_q <= 8'h00;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.datafrommem = rdata_q;
  assign bus.mem_resp    = resp_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Randomised self-checking bench for mem_resp_ctrl against a byte-array reference model.
module tb_mem_resp_ctrl;
  import mem_resp_ctrl_pkg::*;

`ifdef MEM_RESP_CTRL_RANGE_CHK_EN
  localparam int DEPTH = 256;
  localparam bit CHK   = 1'b1;
`else
  localparam int DEPTH = 16384;
  localparam bit CHK   = 1'b0;
`endif
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_resp_ctrl_if bus();

  mem_resp_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mem_m [DEPTH];
  bit         vld_m [DEPTH];
  logic [7:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input bit is_wr, input int a);
    return CHK && (is_wr ? (a + 1 >= DEPTH) : (a >= DEPTH));
  endfunction

  // Issue one request from a negedge, check latency/data/handshake, return at a negedge.
  task automatic do_req(input bit rd, input bit wr, input int a, input logic [15:0] d, input int hold);
    bit is_wr;
    bit err;
    bit seen;
    int lat;
    int pulses;
    is_wr = wr;
    err   = model_err(is_wr, a);
    bus.cs = 1'b1; bus.read_req = rd; bus.write_req = wr;
    bus.addrout = 14'(a); bus.datatomem = d;
    if (is_wr) begin
      if (!err) begin
        mem_m[a % DEPTH] = d[7:0];        vld_m[a % DEPTH] = 1'b1;
        mem_m[(a + 1) % DEPTH] = d[15:8]; vld_m[(a + 1) % DEPTH] = 1'b1;
      end
    end else begin
      last_rd = err ? 8'hFF : mem_m[a % DEPTH];
    end
    seen = 1'b0;
    lat  = 0;
    for (int j = 0; j < 16 && !seen; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check_eq("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        bus.addrout   = 14'($urandom);
        bus.datatomem = 16'($urandom);
      end
      if (bus.mem_resp) begin
        seen = 1'b1;
        lat  = j;
      end
    end
    if (!seen) begin
      check_eq("resp_timeout", 32'd0, 32'd1);
    end else begin
      check_eq(is_wr ? "wr_latency" : "rd_latency", lat, is_wr ? LATENCY + 3 : LATENCY + 2);
      check_eq("datafrommem", {24'd0, bus.datafrommem}, {24'd0, last_rd});
`ifdef MEM_RESP_CTRL_RANGE_CHK_EN
      check_eq("mem_err", {31'd0, bus.mem_err}, {31'd0, err});
`endif
    end
    pulses = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.mem_resp) pulses++;
      check_eq("busy_hold", {31'd0, bus.busy}, 32'd1);
    end
    if (hold > 0) check_eq("single_resp", pulses, 1);
    bus.read_req = 1'b0; bus.write_req = 1'b0; bus.cs = 1'($urandom);
    @(negedge clk);
    check_eq("idle_after_drop", {30'd0, bus.busy, bus.mem_resp}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pulses;
    bus.cs = 1'b0; bus.read_req = 1'b0; bus.write_req = 1'b0;
    bus.addrout = 14'h0000; bus.datatomem = 16'h0000;
    for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
    last_rd = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_datafrommem", {24'd0, bus.datafrommem}, 32'd0);
    check_eq("rst_resp_busy", {30'd0, bus.mem_resp, bus.busy}, 32'd0);
`ifdef MEM_RESP_CTRL_RANGE_CHK_EN
    check_eq("rst_mem_err", {31'd0, bus.mem_err}, 32'd0);
`endif

    do_req(1'b0, 1'b1, 'h0010, 16'hBEEF, 0);
    do_req(1'b1, 1'b0, 'h0010, 16'h0000, 0);
    do_req(1'b1, 1'b0, 'h0011, 16'h0000, 3);
`ifndef MEM_RESP_CTRL_RANGE_CHK_EN
    do_req(1'b0, 1'b1, 'h3FFF, 16'h1234, 1);
    do_req(1'b1, 1'b0, 'h3FFF, 16'h0000, 0);
    do_req(1'b1, 1'b0, 'h0000, 16'h0000, 0);
`endif
    do_req(1'b1, 1'b1, 'h0020, 16'hA55A, 1);
    do_req(1'b1, 1'b0, 'h0020, 16'h0000, 0);
    do_req(1'b1, 1'b0, 'h0021, 16'h0000, 0);

    // Request without chip select must be ignored.
    bus.cs = 1'b0; bus.read_req = 1'b1; bus.write_req = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_resp || bus.busy) pulses++;
    end
    check_eq("cs_low_ignored", pulses, 0);
    bus.read_req = 1'b0; bus.write_req = 1'b0;
    @(negedge clk);

    // Reset during WR_HI of a write: low byte lands, high byte does not, no response.
    do_req(1'b0, 1'b1, 'h0040, 16'h7711, 0);
    do_req(1'b1, 1'b0, 'h0010, 16'h0000, 0);
    bus.cs = 1'b1; bus.write_req = 1'b1; bus.addrout = 14'h0040; bus.datatomem = 16'hCAFE;
    repeat (LATENCY + 2) @(posedge clk);
    @(negedge clk);
    check_eq("busy_before_reset", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1; bus.write_req = 1'b0; bus.cs = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mem_m['h40] = 8'hFE;
    last_rd = 8'h00;
    check_eq("abort_outputs", {22'd0, bus.datafrommem, bus.mem_resp, bus.busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_resp) pulses++;
    end
    check_eq("no_resp_after_abort", pulses, 0);
    do_req(1'b1, 1'b0, 'h0040, 16'h0000, 0);
    do_req(1'b1, 1'b0, 'h0041, 16'h0000, 0);

`ifdef MEM_RESP_CTRL_RANGE_CHK_EN
    do_req(1'b1, 1'b0, 'h0100, 16'h0000, 0);
    do_req(1'b0, 1'b1, 'h00FE, 16'h6655, 0);
    do_req(1'b0, 1'b1, 'h00FF, 16'h9988, 0);
    do_req(1'b1, 1'b0, 'h00FF, 16'h0000, 0);
    do_req(1'b0, 1'b1, 'h0123, 16'h4433, 0);
`endif

    // Random mix of reads/writes over a small window with random holds and idle gaps.
    for (int n = 0; n < 40; n++) begin
      int a;
      bit rd;
      bit wr;
      a = 'h80 + int'($urandom_range(0, 31));
      wr = ($urandom_range(0, 1) == 1) || !vld_m[a];
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      do_req(rd, wr, a, 16'($urandom), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
